// File: rtl/vend_output_driver_if.sv
// Request/actuator bundle between the vending controller and its output driver.
// The controller side takes master, the driver side takes slave.
interface vend_output_driver_if #(
  parameter int CNT_W = 3
);
  logic             dispense;
  logic             change;
  logic             item_drop;
  logic             fault_clr;
  logic             motor_on;
  logic             solenoid_on;
  logic             busy;
  logic             fault;
  logic             overflow;
  logic [CNT_W-1:0] vend_pending;
  logic [CNT_W-1:0] chg_pending;

  modport master (
    output dispense, change, item_drop, fault_clr,
    input  motor_on, solenoid_on, busy, fault, overflow, vend_pending, chg_pending
  );

  modport slave (
    input  dispense, change, item_drop, fault_clr,
    output motor_on, solenoid_on, busy, fault, overflow, vend_pending, chg_pending
  );
endinterface

// File: rtl/vend_output_driver.sv
// Queues dispense/change strobes and serialises them onto the motor and the change solenoid.
// Define CHANGE_FIRST_EN to serve queued change coins ahead of queued vends.
//
// state     | meaning
// IDLE      | nothing running, launches the next queued action
// VEND      | motor pulse, watching for an early item drop
// WAIT_DROP | motor off, waiting for the drop sensor until timeout
// CHANGE    | solenoid pulse
// GAP       | one dead cycle between actuations
// FAULT     | item never dropped, waits for fault_clr
module vend_output_driver #(
  parameter int MOTOR_CYCLES = 8,
  parameter int SOL_CYCLES   = 4,
  parameter int DROP_TIMEOUT = 16,
  parameter int CNT_W        = 3
) (
  input  logic               clk,
  input  logic               reset,
  vend_output_driver_if.slave bus
);

  localparam int TMAX_A = (MOTOR_CYCLES > SOL_CYCLES) ? MOTOR_CYCLES : SOL_CYCLES;
  localparam int TMAX   = (TMAX_A > DROP_TIMEOUT) ? TMAX_A : DROP_TIMEOUT;
  localparam int TMR_W  = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    VEND,
    WAIT_DROP,
    CHANGE,
    GAP,
    FAULT
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             drop_seen;
  logic             motor_q;
  logic             sol_q;
  logic             busy_q;
  logic             fault_q;
  logic             ovf_q;
  logic [CNT_W-1:0] vend_cnt;
  logic [CNT_W-1:0] chg_cnt;

  logic vend_go;
  logic chg_go;
  logic vend_ovf;
  logic chg_ovf;

  // Launch decision depends only on registered state and counts.
  always_comb begin
    vend_go = 1'b0;
    chg_go  = 1'b0;
    if (state == IDLE) begin
`ifdef CHANGE_FIRST_EN
      chg_go  = (chg_cnt != '0);
      vend_go = (vend_cnt != '0) && (chg_cnt == '0);
`else
      vend_go = (vend_cnt != '0);
      chg_go  = (chg_cnt != '0) && (vend_cnt == '0);
`endif
    end
  end

  assign vend_ovf = bus.dispense && !vend_go && (vend_cnt == CNT_MAX);
  assign chg_ovf  = bus.change && !chg_go && (chg_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vend_cnt <= '0;
      chg_cnt  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (bus.dispense && !vend_go) begin
        if (vend_cnt != CNT_MAX) vend_cnt <= vend_cnt + 1'b1;
      end else if (!bus.dispense && vend_go) begin
        vend_cnt <= vend_cnt - 1'b1;
      end

      if (bus.change && !chg_go) begin
        if (chg_cnt != CNT_MAX) chg_cnt <= chg_cnt + 1'b1;
      end else if (!bus.change && chg_go) begin
        chg_cnt <= chg_cnt - 1'b1;
      end

      // A fresh overflow in the clearing cycle is not lost.
      ovf_q <= (ovf_q && !bus.fault_clr) || vend_ovf || chg_ovf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      drop_seen <= 1'b0;
      motor_q   <= 1'b0;
      sol_q     <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (vend_go) begin
            state     <= VEND;
            timer     <= TMR_W'(MOTOR_CYCLES - 1);
            drop_seen <= 1'b0;
            motor_q   <= 1'b1;
            busy_q    <= 1'b1;
          end else if (chg_go) begin
            state  <= CHANGE;
            timer  <= TMR_W'(SOL_CYCLES - 1);
            sol_q  <= 1'b1;
            busy_q <= 1'b1;
          end
        end

        VEND: begin
          if (timer == '0) begin
            motor_q <= 1'b0;
            if (drop_seen || bus.item_drop) begin
              state <= GAP;
            end else begin
              state <= WAIT_DROP;
              timer <= TMR_W'(DROP_TIMEOUT - 1);
            end
          end else begin
            timer     <= timer - TMR_W'(1);
            drop_seen <= drop_seen || bus.item_drop;
          end
        end

        WAIT_DROP: begin
          // A drop on the final timeout cycle still counts as success.
          if (bus.item_drop) begin
            state <= GAP;
          end else if (timer == '0) begin
            state   <= FAULT;
            fault_q <= 1'b1;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end

        CHANGE: begin
          if (timer == '0) begin
            state <= GAP;
            sol_q <= 1'b0;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end

        GAP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end

        FAULT: begin
          if (bus.fault_clr) begin
            state   <= IDLE;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          timer   <= '0;
          motor_q <= 1'b0;
          sol_q   <= 1'b0;
          busy_q  <= 1'b0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.motor_on     = motor_q;
  assign bus.solenoid_on  = sol_q;
  assign bus.busy         = busy_q;
  assign bus.fault        = fault_q;
  assign bus.overflow     = ovf_q;
  assign bus.vend_pending = vend_cnt;
  assign bus.chg_pending  = chg_cnt;

endmodule

// File: tb/tb_vend_output_driver.sv
// Directed bench for vend_output_driver: per-cycle vector tables plus hand sequences
// for timeout, saturation, late drop and mid-pulse reset.
module tb_vend_output_driver;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  vend_output_driver_if #(.CNT_W(3)) bus ();

  vend_output_driver #(
    .MOTOR_CYCLES(8),
    .SOL_CYCLES  (4),
    .DROP_TIMEOUT(16),
    .CNT_W       (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  in_v;   // dispense, change, item_drop, fault_clr
    logic [10:0] exp_v;  // motor, sol, busy, fault, overflow, vend_pending[3], chg_pending[3]
  } vec_t;

  vec_t tbl[$];

  function automatic logic [10:0] outs();
    return {bus.motor_on, bus.solenoid_on, bus.busy, bus.fault, bus.overflow,
            bus.vend_pending, bus.chg_pending};
  endfunction

  task automatic add(input logic d, input logic c, input logic dr, input logic clr,
                     input logic m, input logic s, input logic b, input logic f,
                     input logic o, input int vp, input int cp);
    vec_t v;
    v.in_v  = {d, c, dr, clr};
    v.exp_v = {m, s, b, f, o, 3'(vp), 3'(cp)};
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [10:0] got, input logic [10:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got m/s/b/f/o=%b vp=%0d cp=%0d, want m/s/b/f/o=%b vp=%0d cp=%0d",
               name, got[10:6], got[5:3], got[2:0], want[10:6], want[5:3], want[2:0]);
    end
  endtask

  task automatic chk1(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic cyc(input logic d, input logic c, input logic dr, input logic clr);
    bus.dispense  = d;
    bus.change    = c;
    bus.item_drop = dr;
    bus.fault_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].in_v[3], tbl[i].in_v[2], tbl[i].in_v[1], tbl[i].in_v[0]);
      chk($sformatf("%s row %0d", tag, i), outs(), tbl[i].exp_v);
    end
    tbl.delete();
  endtask

  initial begin
    int rises;
    int sol_cnt;
    int waited;
    logic prev_m;

    total = 0;
    bad   = 0;
    bus.dispense  = 1'b0;
    bus.change    = 1'b0;
    bus.item_drop = 1'b0;
    bus.fault_clr = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", outs(), 11'd0);
    reset = 1'b0;

    // Single vend, drop seen in the 3rd motor cycle
    add(1,0,0,0, 0,0,0,0,0, 1,0);
    add(0,0,0,0, 1,0,1,0,0, 0,0);
    add(0,0,0,0, 1,0,1,0,0, 0,0);
    add(0,0,0,0, 1,0,1,0,0, 0,0);
    add(0,0,1,0, 1,0,1,0,0, 0,0);
    for (int k = 5; k <= 8; k++) add(0,0,0,0, 1,0,1,0,0, 0,0);
    add(0,0,0,0, 0,0,1,0,0, 0,0);
    add(0,0,0,0, 0,0,0,0,0, 0,0);
    add(0,0,0,0, 0,0,0,0,0, 0,0);
    run_table("single vend");

    // Dispense and change together
    add(1,1,1,0, 0,0,0,0,0, 1,1);
`ifdef CHANGE_FIRST_EN
    for (int k = 1; k <= 4; k++) add(0,0,1,0, 0,1,1,0,0, 1,0);
    add(0,0,1,0, 0,0,1,0,0, 1,0);
    add(0,0,1,0, 0,0,0,0,0, 1,0);
    for (int k = 7; k <= 14; k++) add(0,0,1,0, 1,0,1,0,0, 0,0);
    add(0,0,1,0, 0,0,1,0,0, 0,0);
    add(0,0,1,0, 0,0,0,0,0, 0,0);
`else
    for (int k = 1; k <= 8; k++) add(0,0,1,0, 1,0,1,0,0, 0,1);
    add(0,0,1,0, 0,0,1,0,0, 0,1);
    add(0,0,1,0, 0,0,0,0,0, 0,1);
    for (int k = 11; k <= 14; k++) add(0,0,1,0, 0,1,1,0,0, 0,0);
    add(0,0,1,0, 0,0,1,0,0, 0,0);
    add(0,0,1,0, 0,0,0,0,0, 0,0);
`endif
    run_table("dual request");

    // No drop: timeout into FAULT, change queued but held off
    cyc(1,0,0,0);
    for (int k = 1; k <= 24; k++) cyc(0,0,0,0);
    chk("timeout last wait", outs(), {5'b00100, 3'd0, 3'd0});
    cyc(0,0,0,0);
    chk("timeout fault", outs(), {5'b00110, 3'd0, 3'd0});
    cyc(0,1,0,0);
    chk("change in fault", outs(), {5'b00110, 3'd0, 3'd1});
    sol_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(0,0,0,0);
      sol_cnt += int'(bus.solenoid_on);
    end
    chk1("no solenoid in fault", sol_cnt, 0);
    cyc(0,0,0,1);
    chk("fault_clr to idle", outs(), {5'b00000, 3'd0, 3'd1});
    cyc(0,0,0,0);
    chk("post-fault change", outs(), {5'b01100, 3'd0, 3'd0});
    sol_cnt = 1;
    for (int k = 0; k < 6; k++) begin
      cyc(0,0,0,0);
      sol_cnt += int'(bus.solenoid_on);
    end
    chk1("post-fault sol width", sol_cnt, 4);
    chk("post-fault idle", outs(), 11'd0);

    // Saturation and overflow clear
    for (int k = 0; k < 9; k++) cyc(1,0,1,0);
    chk("saturated", outs(), {5'b10101, 3'd7, 3'd0});
    cyc(0,0,1,1);
    chk("overflow cleared", outs(), {5'b00100, 3'd7, 3'd0});
    rises  = 0;
    prev_m = 1'b0;
    waited = 0;
    while (!(bus.busy == 1'b0 && bus.vend_pending == 3'd0) && waited < 300) begin
      cyc(0,0,1,0);
      if (bus.motor_on && !prev_m) rises++;
      prev_m = bus.motor_on;
      waited++;
    end
    chk1("drain finished in budget", int'(waited < 300), 1);
    chk1("drained vend count", rises, 7);
    chk("after drain", outs(), 11'd0);

    // Drop on the final timeout cycle
    cyc(1,0,0,0);
    for (int k = 1; k <= 24; k++) cyc(0,0,0,0);
    cyc(0,0,1,0);
    chk("late drop gap", outs(), {5'b00100, 3'd0, 3'd0});
    cyc(0,0,0,0);
    chk("late drop idle", outs(), 11'd0);

    // Reset in the 2nd solenoid cycle with two coins queued
    cyc(0,1,0,0);
    cyc(0,1,0,0);
    cyc(0,1,0,0);
    chk("before reset", outs(), {5'b01100, 3'd0, 3'd2});
    bus.change = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async reset", outs(), 11'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sol_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(0,0,0,0);
      sol_cnt += int'(bus.busy);
    end
    chk1("busy after reset", sol_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
